// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// RV32 instruction-fetch program counter. Holds the current fetch address,
// advances it by STEP bytes per cycle, accepts redirects from branch/jump/trap
// logic and can be frozen by a pipeline stall. A redirect takes priority over
// a stall.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   defined     - a misaligned redirect (pc[1:0] != 0) loads TRAP_VECTOR
//   not defined - a misaligned redirect loads the word-aligned target
//   In both builds misaligned pulses high for one cycle after such a load.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   pc         in   [31:0] redirect target address
//   pc_load    in   redirect strobe, target loaded on the next clk edge
//   stall      in   hold the current address
//   next_pc    out  [31:0] registered current fetch address
//   pc_plus4   out  [31:0] combinational next_pc + STEP (link value)
//   pc_valid   out  registered, high once out of reset
//   misaligned out  registered one-cycle pulse after a misaligned redirect
// ---------------------------------------------------------------------------
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] STEP         = 32'd4,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_load,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        misaligned
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [31:0] next_pc_reg;
  logic [31:0] next_pc_next;
  logic        pc_valid_reg;
  logic        misaligned_reg;
  logic        misaligned_next;
  logic        target_misaligned;
  logic [31:0] aligned_target;
  logic [31:0] redirect_target;

  // Low two address bits must be zero for a 32-bit instruction fetch.
  assign target_misaligned = |pc[1:0];

  // Clear the byte-offset bits of the redirect target.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_align
      if (gi < 2) begin : g_low
        assign aligned_target[gi] = 1'b0;
      end else begin : g_high
        assign aligned_target[gi] = pc[gi];
      end
    end
  endgenerate

  // A misaligned target is either masked down or replaced by the trap vector.
  assign redirect_target = !target_misaligned ? pc :
                           (TRAP_EN ? TRAP_VECTOR : aligned_target);

  always_comb begin
    next_pc_next    = next_pc_reg;
    misaligned_next = 1'b0;
    if (pc_load) begin
      next_pc_next    = redirect_target;
      misaligned_next = target_misaligned;
    end else if (!stall) begin
      // 32-bit add wraps naturally modulo 2^32.
      next_pc_next = next_pc_reg + STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pc_reg    <= RESET_VECTOR;
      pc_valid_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      next_pc_reg    <= next_pc_next;
      pc_valid_reg   <= 1'b1;
      misaligned_reg <= misaligned_next;
    end
  end

  assign next_pc    = next_pc_reg;
  assign pc_plus4   = next_pc_reg + STEP;
  assign pc_valid   = pc_valid_reg;
  assign misaligned = misaligned_reg;

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//
// Self-checking bench for program_counter: a directed vector table applied
// cycle by cycle, a hand-written asynchronous-reset sequence, then randomized
// stimulus compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_program_counter;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_load;
  logic        stall;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  program_counter dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_load    (pc_load),
    .stall      (stall),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .pc_valid   (pc_valid),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        pc_load;
    logic        stall;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [31:0] p, input logic l,
                              input logic s, input logic [31:0] e,
                              input logic v, input logic m);
    vec_t t;
    t.rst = r; t.pc = p; t.pc_load = l; t.stall = s;
    t.exp_pc = e; t.exp_valid = v; t.exp_mis = m;
    return t;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc,
                           input logic e_valid, input logic e_mis);
    logic [31:0] e_plus;
    e_plus = e_pc + 32'd4;
    chk32({tag, ".next_pc"},    next_pc,           e_pc);
    chk32({tag, ".pc_plus4"},   pc_plus4,          e_plus);
    chk32({tag, ".pc_valid"},   {31'd0, pc_valid},  {31'd0, e_valid});
    chk32({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
    $display("%s next_pc=%h pc_plus4=%h valid=%0b mis=%0b", tag, next_pc,
             pc_plus4, pc_valid, misaligned);
  endtask

  task automatic apply(input logic r, input logic [31:0] p, input logic l, input logic s);
    @(negedge clk);
    rst = r; pc = p; pc_load = l; stall = s;
    @(posedge clk);
    #1;
  endtask

  // Reference model state.
  longint m_pc;
  bit     m_valid;
  bit     m_mis;

  task automatic model_step(input bit r, input longint p, input bit l, input bit s);
    if (r) begin
      m_pc = 0; m_valid = 0; m_mis = 0;
    end else begin
      m_valid = 1;
      m_mis   = 0;
      if (l) begin
        if (p % 4 != 0) begin
          m_mis = 1;
          m_pc  = TRAP ? 256 : p - (p % 4);
        end else begin
          m_pc = p;
        end
      end else if (!s) begin
        m_pc = (m_pc + 4) % 64'h1_0000_0000;
      end
    end
  endtask

  initial begin
    logic [31:0] mis_a;
    logic [31:0] mis_b;
    rst = 1'b1; pc = 32'h1; pc_load = 1'b1; stall = 1'b0;

    mis_a = TRAP ? 32'h100 : 32'h1000;
    mis_b = TRAP ? 32'h100 : 32'h7000;

    // Reset with a pending load, release, advance, stall, priority, wrap,
    // misaligned redirects (including back-to-back).
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 32'h1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'd4,  1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'd8,  1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'd12, 1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'd16, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 32'd16, 1, 0));
    vecs.push_back(mk(0, 32'h2000, 1, 1, 32'h2000, 1, 0));
    vecs.push_back(mk(0, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 32'h1003, 1, 0, mis_a, 1, 1));
    vecs.push_back(mk(0, 32'h0, 0, 0, mis_a + 32'd4, 1, 0));
    vecs.push_back(mk(0, 32'h7001, 1, 0, mis_b, 1, 1));
    vecs.push_back(mk(0, 32'h7002, 1, 1, mis_b, 1, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, mis_b, 1, 0));
    vecs.push_back(mk(0, 32'h2008, 1, 0, 32'h2008, 1, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].pc, vecs[i].pc_load, vecs[i].stall);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid, vecs[i].exp_mis);
    end

    // Reset asserted mid-cycle while a redirect is pending: must act before the edge.
    @(negedge clk);
    pc = 32'h5000; pc_load = 1'b1; stall = 1'b0;
    #2 rst = 1'b1;
    #1 check_all("async_rst", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_all("async_rst_edge", 32'h0, 1'b0, 1'b0);
    apply(0, 32'h0, 0, 0);
    check_all("async_release", 32'h4, 1'b1, 1'b0);

    // Randomized stimulus against the model, starting from a clean reset.
    apply(1, 32'h0, 0, 0);
    model_step(1, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      bit          r, l, s;
      logic [31:0] p;
      r = ($urandom_range(0, 24) == 0);
      l = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 2) == 0);
      p = $urandom();
      if ($urandom_range(0, 1) == 0) p[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) p = 32'hFFFF_FFF8;
      apply(r, p, l, s);
      model_step(r, longint'(p), l, s);
      check_all($sformatf("rnd%0d r=%0b l=%0b s=%0b pc=%h", n, r, l, s, p),
                m_pc[31:0], m_valid, m_mis);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
